// File: rtl/dff_lib_pkg.sv
// Shared state encodings for the dff-library conditioning blocks.
// Combinational constants only; no latency, no flow control.
package dff_lib_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous 1-bit level.
// Latency 2 clk; no backpressure.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Debounces raw din into dout with rise/fall strobes; dout flips N+STABLE_CYCLES edges after din settles
// (N=2 with DEBOUNCE_SYNC_EN defined, else N=1); no backpressure, en=0 freezes dout.
module input_debouncer
    import dff_lib_pkg::*;
#(
    parameter int   CNT_W         = 8,
    parameter int   STABLE_CYCLES = 16,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic en,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

`ifdef DEBOUNCE_SYNC_EN
    sync_2ff #(
        .RESET_VAL (RESET_VAL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (din),
        .q     (s)
    );
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s <= RESET_VAL;
        end else begin
            s <= din;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            dout_q  <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (!en) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_STABLE: begin
                    if (s != dout_q) begin
                        state_d = ST_CHECK;
                        cnt_d   = CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    // a single sample matching dout means the edge was a bounce
                    if (s == dout_q) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        dout_d  = s;
                        rise_d  = s;
                        fall_d  = ~s;
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == ST_CHECK);

endmodule

// File: tb/tb_input_debouncer.sv
// Randomized and directed bench for input_debouncer against a window-counting reference model.
module tb_input_debouncer;

    localparam int   CNT_W         = 4;
    localparam int   STABLE_CYCLES = 4;
    localparam logic RESET_VAL     = 1'b0;
`ifdef DEBOUNCE_SYNC_EN
    localparam int   N             = 2;
`else
    localparam int   N             = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic din = 1'b0;
    logic en = 1'b1;
    logic dout, rise, fall, busy;

    int checks = 0;
    int errors = 0;

    input_debouncer #(
        .CNT_W         (CNT_W),
        .STABLE_CYCLES (STABLE_CYCLES),
        .RESET_VAL     (RESET_VAL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .en    (en),
        .dout  (dout),
        .rise  (rise),
        .fall  (fall),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: s is din seen N edges late; dout accepts s once s has
    // differed from dout on STABLE_CYCLES consecutive enabled edges.
    logic m_pipe [N];
    logic m_dout = RESET_VAL;
    logic m_rise = 1'b0;
    logic m_fall = 1'b0;
    int   m_streak = 0;
    logic din_s, en_s, rst_s, s_m;

    always @(posedge clk) begin
        din_s = din;
        en_s  = en;
        rst_s = reset;
        #1;
        if (!rst_s) begin
            for (int i = 0; i < N; i++) m_pipe[i] = RESET_VAL;
            m_dout   = RESET_VAL;
            m_rise   = 1'b0;
            m_fall   = 1'b0;
            m_streak = 0;
        end else begin
            s_m = m_pipe[N-1];
            for (int i = N-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = din_s;
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (!en_s || s_m == m_dout) begin
                m_streak = 0;
            end else begin
                m_streak++;
                if (m_streak == STABLE_CYCLES) begin
                    m_rise   = s_m;
                    m_fall   = ~s_m;
                    m_dout   = s_m;
                    m_streak = 0;
                end
            end
        end
        chk("model_dout", dout, m_dout);
        chk("model_rise", rise, m_rise);
        chk("model_fall", fall, m_fall);
        chk("model_busy", busy, logic'(m_streak != 0));
        chk("rise_fall_excl", rise & fall, 1'b0);
    end

    task automatic edge_sample();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic r, input logic d, input logic e);
        @(negedge clk);
        reset = r;
        din   = d;
        en    = e;
    endtask

    initial begin
        // 1: reset with din=1
        #1 reset = 1'b0;
        din = 1'b1;
        for (int k = 0; k < 2; k++) begin
            edge_sample();
            chk("rst_dout", dout, 1'b0);
            chk("rst_rise", rise, 1'b0);
            chk("rst_fall", fall, 1'b0);
            chk("rst_busy", busy, 1'b0);
        end
        drive(1'b1, 1'b0, 1'b1);
        repeat (6) edge_sample();

        // 2: clean 0->1
        drive(1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= N + STABLE_CYCLES + 1; k++) begin
            edge_sample();
            chk("t2_busy", busy, logic'(k >= N + 1 && k < N + STABLE_CYCLES));
            chk("t2_dout", dout, logic'(k >= N + STABLE_CYCLES));
            chk("t2_rise", rise, logic'(k == N + STABLE_CYCLES));
        end
        repeat (2) edge_sample();

        // 4: 1->0 held
        drive(1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= N + STABLE_CYCLES + 1; k++) begin
            edge_sample();
            chk("t4_dout", dout, logic'(k < N + STABLE_CYCLES));
            chk("t4_fall", fall, logic'(k == N + STABLE_CYCLES));
        end

        // 3: two-cycle glitch
        begin
            logic seen_busy;
            seen_busy = 1'b0;
            drive(1'b1, 1'b1, 1'b1);
            edge_sample();
            edge_sample();
            seen_busy = seen_busy | busy;
            drive(1'b1, 1'b0, 1'b1);
            for (int k = 0; k < 8; k++) begin
                edge_sample();
                seen_busy = seen_busy | busy;
                chk("t3_dout", dout, 1'b0);
                chk("t3_rise", rise, 1'b0);
                chk("t3_fall", fall, 1'b0);
            end
            chk("t3_busy_seen", seen_busy, 1'b1);
        end

        // 5: en=0 freezes, en=1 starts a full window
        drive(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            edge_sample();
            chk("t5_frozen_dout", dout, 1'b0);
            chk("t5_frozen_busy", busy, 1'b0);
        end
        drive(1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= STABLE_CYCLES; k++) begin
            edge_sample();
            chk("t5_dout", dout, logic'(k == STABLE_CYCLES));
            chk("t5_rise", rise, logic'(k == STABLE_CYCLES));
        end

        // 6: reset during qualification
        drive(1'b1, 1'b0, 1'b1);
        repeat (N + STABLE_CYCLES + 2) edge_sample();
        chk("t6_pre_dout", dout, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        repeat (N + 2) edge_sample();
        chk("t6_busy_before", busy, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        #1;
        chk("t6_async_dout", dout, 1'b0);
        chk("t6_async_busy", busy, 1'b0);
        chk("t6_async_rise", rise, 1'b0);
        repeat (2) edge_sample();
        drive(1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= N + STABLE_CYCLES; k++) begin
            edge_sample();
            chk("t6_window_dout", dout, logic'(k == N + STABLE_CYCLES));
        end

        // randomized bouncy stimulus
        begin
            logic lvl, r, e, d;
            int   hold;
            lvl = 1'b0;
            for (int c = 0; c < 4000; c++) begin
                if (hold <= 0) begin
                    lvl  = logic'($urandom_range(0, 1));
                    hold = int'($urandom_range(1, 9));
                end
                hold--;
                d = ($urandom_range(0, 9) == 0) ? ~lvl : lvl;
                e = ($urandom_range(0, 19) != 0);
                r = ($urandom_range(0, 299) != 0);
                drive(r, d, e);
                if (!r) begin
                    drive(1'b0, d, e);
                end
            end
        end
        drive(1'b1, 1'b0, 1'b1);
        repeat (3) edge_sample();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
